// File: rtl/cv1k_pkg.sv
// Shared types and constants for the CS4 serial EEPROM/RTC engine.
package cv1k_pkg;

    localparam int MAX_BITS_DEF = 32;
    localparam int LEN_W        = 6;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        TX,
        RX,
        HOLD,
        RECOVER
    } state_t;

    // Lengths above the shift-register width saturate instead of wrapping.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                    input int max_bits);
        if (int'(len) > max_bits)
            return LEN_W'(max_bits);
        return len;
    endfunction

endpackage

// File: rtl/serial_phase_gen.sv
// Half-period divider for the serial clock: CLK_DIV cycles low, then CLK_DIV high.
module serial_phase_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    output logic phase_high,
    output logic end_of_low,
    output logic end_of_high
);

    localparam int CW = $clog2(CLK_DIV) + 1;

    logic [CW-1:0] cnt;
    logic          last;

    assign last = (cnt == CW'(CLK_DIV - 1));

    // Dropping run parks the divider at the start of a low phase, so the
    // serial clock idles low and every bit sequence begins with a full low phase.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clock) begin
        if (reset || !run) begin
            cnt        <= '0;
            phase_high <= 1'b0;
        end else if (last) begin
            cnt        <= '0;
            phase_high <= !phase_high;
        end else begin
            cnt        <= cnt + 1'b1;
        end
    end

    assign end_of_low  = run && !phase_high && last;
    assign end_of_high = run &&  phase_high && last;

endmodule

// File: rtl/eeprom_serial_ctrl.sv
// Whole-transaction serial engine for the EEPROM/RTC pins: CE setup, command
// shift-out, optional read shift-in, CE hold and CE-low recovery.
module eeprom_serial_ctrl
    import cv1k_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CE_SETUP = 2,
    parameter int CE_HOLD  = 2,
    parameter int MAX_BITS = MAX_BITS_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [MAX_BITS-1:0] cmd_data,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [LEN_W-1:0]    rd_len,
    output logic                busy,
    output logic                done,
    output logic [MAX_BITS-1:0] rd_data,
    output logic                eeprom_ce,
    output logic                eeprom_clock,
    output logic                eeprom_di,
    input  logic                eeprom_do
);

    localparam int WAIT_MAX = (CE_SETUP > CE_HOLD) ? CE_SETUP : CE_HOLD;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

    state_t              state, state_d;
    logic [WAIT_W-1:0]   wait_cnt, wait_d;
    logic [LEN_W-1:0]    bit_cnt, bit_d;
    logic [LEN_W-1:0]    cmd_len_q, cmd_len_d;
    logic [LEN_W-1:0]    rd_len_q, rd_len_d;
    logic [MAX_BITS-1:0] tx_shift, tx_d;
    logic [MAX_BITS-1:0] rd_d;
    logic                busy_d, done_d, ce_d, di_d;

    logic phase_high, end_of_low, end_of_high;
    logic serial_run;

    assign serial_run = (state == TX) || (state == RX);

    serial_phase_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_phase (
        .clock       (clock),
        .reset       (reset),
        .run         (serial_run),
        .phase_high  (phase_high),
        .end_of_low  (end_of_low),
        .end_of_high (end_of_high)
    );

    // The divider's phase flop is itself the serial clock register.
    assign eeprom_clock = phase_high;

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_d   = state;
        wait_d    = wait_cnt;
        bit_d     = bit_cnt;
        cmd_len_d = cmd_len_q;
        rd_len_d  = rd_len_q;
        tx_d      = tx_shift;
        rd_d      = rd_data;
        busy_d    = busy;
        done_d    = 1'b0;
        ce_d      = eeprom_ce;
        di_d      = 1'b0;

        case (state)
            IDLE: begin
                busy_d = 1'b0;
                ce_d   = 1'b0;
                if (start) begin
                    cmd_len_d = clamp_len(cmd_len, MAX_BITS);
                    rd_len_d  = clamp_len(rd_len, MAX_BITS);
                    // Left-align the command so its first bit sits at the MSB.
                    tx_d      = cmd_data << (MAX_BITS - int'(cmd_len_d));
                    rd_d      = '0;
                    wait_d    = '0;
                    busy_d    = 1'b1;
                    ce_d      = 1'b1;
                    state_d   = SETUP;
                end
            end

            SETUP: begin
                if (wait_cnt == WAIT_W'(CE_SETUP - 1)) begin
                    wait_d = '0;
                    if (cmd_len_q != '0) begin
                        state_d = TX;
                        bit_d   = cmd_len_q;
                        di_d    = tx_shift[MAX_BITS-1];
                    end else if (rd_len_q != '0) begin
                        state_d = RX;
                        bit_d   = rd_len_q;
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    wait_d = wait_cnt + 1'b1;
                end
            end

            TX: begin
                di_d = tx_shift[MAX_BITS-1];
                if (end_of_high) begin
                    if (bit_cnt == LEN_W'(1)) begin
                        di_d    = 1'b0;
                        bit_d   = rd_len_q;
                        state_d = (rd_len_q != '0) ? RX : HOLD;
                    end else begin
                        bit_d = bit_cnt - 1'b1;
                        tx_d  = tx_shift << 1;
                        di_d  = tx_d[MAX_BITS-1];
                    end
                end
            end

            RX: begin
                if (end_of_high) begin
                    rd_d = {rd_data[MAX_BITS-2:0], eeprom_do};
                    if (bit_cnt == LEN_W'(1)) begin
                        bit_d   = '0;
                        state_d = HOLD;
                    end else begin
                        bit_d = bit_cnt - 1'b1;
                    end
                end
            end

            HOLD: begin
                if (wait_cnt == WAIT_W'(CE_HOLD - 1)) begin
                    wait_d  = '0;
                    ce_d    = 1'b0;
                    state_d = RECOVER;
                end else begin
                    wait_d = wait_cnt + 1'b1;
                end
            end

            RECOVER: begin
                if (wait_cnt == WAIT_W'(CE_SETUP - 1)) begin
                    wait_d  = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_cnt + 1'b1;
                end
            end

            default: begin
                busy_d  = 1'b0;
                ce_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Reset aborts outright: CE drops on the next edge with no hold or recovery.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            bit_cnt   <= '0;
            cmd_len_q <= '0;
            rd_len_q  <= '0;
            tx_shift  <= '0;
            rd_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            eeprom_ce <= 1'b0;
            eeprom_di <= 1'b0;
        end else begin
            state     <= state_d;
            wait_cnt  <= wait_d;
            bit_cnt   <= bit_d;
            cmd_len_q <= cmd_len_d;
            rd_len_q  <= rd_len_d;
            tx_shift  <= tx_d;
            rd_data   <= rd_d;
            busy      <= busy_d;
            done      <= done_d;
            eeprom_ce <= ce_d;
            eeprom_di <= di_d;
        end
    end

    // Silences the unused-signal path: end_of_low is part of the divider's
    // interface but this engine only needs the sample strobe.
    logic unused_eol;
    assign unused_eol = end_of_low;

endmodule

// File: tb/tb_eeprom_serial_ctrl.sv
// Self-checking bench for eeprom_serial_ctrl: pin waveforms and read data are
// compared against a timeline model built from the transaction rules.
module tb_eeprom_serial_ctrl;

    localparam int D  = 4;
    localparam int S  = 2;
    localparam int H  = 2;
    localparam int MB = 32;

    typedef struct packed {
        logic ce;
        logic clk;
        logic di;
        logic busy;
        logic done;
    } pins_t;

    logic          clock;
    logic          reset;
    logic          start;
    logic [MB-1:0] cmd_data;
    logic [5:0]    cmd_len;
    logic [5:0]    rd_len;
    logic          busy;
    logic          done;
    logic [MB-1:0] rd_data;
    logic          eeprom_ce;
    logic          eeprom_clock;
    logic          eeprom_di;
    logic          eeprom_do;

    int checks = 0;
    int errors = 0;

    eeprom_serial_ctrl #(
        .CLK_DIV  (D),
        .CE_SETUP (S),
        .CE_HOLD  (H),
        .MAX_BITS (MB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .cmd_data     (cmd_data),
        .cmd_len      (cmd_len),
        .rd_len       (rd_len),
        .busy         (busy),
        .done         (done),
        .rd_data      (rd_data),
        .eeprom_ce    (eeprom_ce),
        .eeprom_clock (eeprom_clock),
        .eeprom_di    (eeprom_di),
        .eeprom_do    (eeprom_do)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Device model: after the command bits it presents the read word MSB-first,
    // advancing on each falling serial clock.
    logic [MB-1:0] dev_word = '0;
    int            dev_c    = 0;
    int            dev_r    = 0;
    int            fall_cnt = 0;
    int            rises    = 0;
    int            toggles  = 0;
    int            dones    = 0;

    always @(negedge eeprom_clock) fall_cnt++;
    always @(posedge eeprom_clock) rises++;
    always @(eeprom_clock) toggles++;
    always @(negedge clock) if (done === 1'b1) dones++;

    always_comb begin
        eeprom_do = 1'b0;
        if (eeprom_ce && fall_cnt >= dev_c && fall_cnt < dev_c + dev_r)
            eeprom_do = dev_word[dev_r - 1 - (fall_cnt - dev_c)];
    end

    function automatic int clampi(input int x);
        return (x > MB) ? MB : x;
    endfunction

    // Expected pins for the cycle after edge k, edge 0 being the start edge.
    function automatic pins_t model(input int k, input logic [MB-1:0] cmd,
                                    input int c, input int r);
        pins_t p;
        int tx_end, rx_end, hold_end, n, j, b;
        p        = '0;
        tx_end   = S + 2 * D * c;
        rx_end   = tx_end + 2 * D * r;
        hold_end = rx_end + H;
        n        = hold_end + S;
        if (k < n)        p.busy = 1'b1;
        if (k == n)       p.done = 1'b1;
        if (k < hold_end) p.ce   = 1'b1;
        if (k >= S && k < rx_end) begin
            j     = k - S;
            b     = j / (2 * D);
            p.clk = ((j % (2 * D)) >= D);
            if (b < c) p.di = cmd[c - 1 - b];
        end
        return p;
    endfunction

    task automatic launch(input logic [MB-1:0] cmd, input int c, input int r,
                          input logic [MB-1:0] word);
        cmd_data = cmd;
        cmd_len  = 6'(c);
        rd_len   = 6'(r);
        dev_word = word;
        dev_c    = clampi(c);
        dev_r    = clampi(r);
        fall_cnt = 0;
        start    = 1'b1;
    endtask

    // Follows a launched transaction from edge 0 to its done cycle.
    task automatic check_txn(input string name, input logic [MB-1:0] cmd,
                             input int c, input int r, input logic [MB-1:0] word,
                             input bit keep_start);
        int cc, rr, n, bad, first_k, rises0;
        pins_t obs, exp_p, first_obs, first_exp;
        logic [63:0] mask;
        logic [MB-1:0] exp_rd;
        cc      = clampi(c);
        rr      = clampi(r);
        n       = S + 2 * D * (cc + rr) + H + S;
        bad     = 0;
        first_k = -1;
        first_obs = '0;
        first_exp = '0;
        rises0  = rises;
        for (int k = 0; k <= n; k++) begin
            @(negedge clock);
            if (k == 0) begin
                cmd_data = $urandom;
                cmd_len  = 6'($urandom);
                rd_len   = 6'($urandom);
                if (!keep_start) start = 1'b0;
            end
            obs   = {eeprom_ce, eeprom_clock, eeprom_di, busy, done};
            exp_p = model(k, cmd, cc, rr);
            if (obs !== exp_p) begin
                bad++;
                if (first_k < 0) begin
                    first_k   = k;
                    first_obs = obs;
                    first_exp = exp_p;
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s waveform: %0d bad cycles, first at cycle %0d: ce,clk,di,busy,done got %b required %b",
                     name, bad, first_k, first_obs, first_exp);
        end
        checks++;
        if (rises - rises0 != cc + rr) begin
            errors++;
            $display("FAIL %s clock_pulses: got %0d required %0d", name, rises - rises0, cc + rr);
        end
        mask   = (64'd1 << rr) - 64'd1;
        exp_rd = word & mask[MB-1:0];
        checks++;
        if (rd_data !== exp_rd) begin
            errors++;
            $display("FAIL %s rd_data: got %h required %h", name, rd_data, exp_rd);
        end
    endtask

    task automatic test_reset();
        int t0;
        logic any;
        reset    = 1'b1;
        start    = 1'b0;
        cmd_data = '0;
        cmd_len  = '0;
        rd_len   = '0;
        repeat (3) @(negedge clock);
        checks++;
        if ({busy, done, eeprom_ce, eeprom_clock, eeprom_di} !== 5'b0 || rd_data !== '0) begin
            errors++;
            $display("FAIL reset_state: busy,done,ce,clk,di got %b rd_data %h required all zero",
                     {busy, done, eeprom_ce, eeprom_clock, eeprom_di}, rd_data);
        end
        reset = 1'b0;
        t0    = toggles;
        any   = 1'b0;
        repeat (10) begin
            @(negedge clock);
            if ({busy, done, eeprom_ce, eeprom_clock, eeprom_di} !== 5'b0 || rd_data !== '0)
                any = 1'b1;
        end
        checks++;
        if (any !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs: got nonzero output while idle required all zero");
        end
        checks++;
        if (toggles != t0) begin
            errors++;
            $display("FAIL idle_clock: got %0d serial clock toggles required 0", toggles - t0);
        end
    endtask

    task automatic test_write();
        launch(32'hA5, 8, 0, '0);
        check_txn("write_a5", 32'hA5, 8, 0, '0, 1'b0);
    endtask

    task automatic test_read();
        logic [MB-1:0] held;
        launch(32'h6, 4, 8, 32'h3C);
        check_txn("read_3c", 32'h6, 4, 8, 32'h3C, 1'b0);
        held = 32'h0000_003C;
        repeat (5) @(negedge clock);
        checks++;
        if (rd_data !== held || busy !== 1'b0) begin
            errors++;
            $display("FAIL read_hold: rd_data got %h busy %b required %h busy 0", rd_data, busy, held);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        logic [MB-1:0] a, b, w1, w2;
        a  = $urandom;
        b  = $urandom;
        w1 = $urandom;
        w2 = $urandom;
        d0 = dones;
        launch(a, 5, 3, w1);
        check_txn("b2b_first", a, 5, 3, w1, 1'b1);
        launch(b, 6, 2, w2);
        check_txn("b2b_second", b, 6, 2, w2, 1'b0);
        repeat (20) @(negedge clock);
        checks++;
        if (dones - d0 != 2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d pulses busy %b required 2 pulses busy 0", dones - d0, busy);
        end
    endtask

    task automatic test_reset_abort();
        int d0;
        logic ce_seen;
        logic [MB-1:0] a;
        a = $urandom;
        launch(a, 8, 0, '0);
        for (int k = 0; k <= 20; k++) begin
            @(negedge clock);
            if (k == 0) start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({eeprom_ce, eeprom_clock, eeprom_di, busy, done} !== 5'b0) begin
            errors++;
            $display("FAIL abort_pins: ce,clk,di,busy,done got %b required 00000",
                     {eeprom_ce, eeprom_clock, eeprom_di, busy, done});
        end
        reset   = 1'b0;
        d0      = dones;
        ce_seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            ce_seen = ce_seen | eeprom_ce;
        end
        checks++;
        if (dones != d0 || ce_seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d done pulses ce_seen %b required 0 and 0", dones - d0, ce_seen);
        end
        a = $urandom;
        launch(a, 7, 5, 32'h15);
        check_txn("after_abort", a, 7, 5, 32'h15, 1'b0);
    endtask

    task automatic test_clamp();
        logic [MB-1:0] a, w;
        a = $urandom;
        w = $urandom;
        launch(a, 40, 0, '0);
        check_txn("clamp_cmd40", a, 40, 0, '0, 1'b0);
        launch(a, 0, 0, '0);
        check_txn("zero_len", a, 0, 0, '0, 1'b0);
        launch(a, 3, 45, w);
        check_txn("clamp_rd45", a, 3, 45, w, 1'b0);
    endtask

    task automatic test_random();
        logic [MB-1:0] a, w;
        int c, r;
        bit keep;
        for (int i = 0; i < 12; i++) begin
            a    = $urandom;
            w    = $urandom;
            c    = $urandom_range(0, 34);
            r    = $urandom_range(0, 34);
            keep = (i != 11) && ($urandom_range(0, 2) == 0);
            launch(a, c, r, w);
            check_txn($sformatf("rand%0d", i), a, c, r, w, keep);
        end
        start = 1'b0;
        repeat (5) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_abort();
        test_clamp();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
